// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte FIFO and launch sequencer sitting in front of the UART TX frame
// controller. The host pushes bytes into a circular FIFO. Whenever the
// transmitter is idle, the head byte is offered on p_data with a one-cycle
// data_valid pulse. The head byte is held until busy falls at end of frame
// and is only popped at that point, so frames go out back-to-back.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   wr_en      host write strobe
//   wr_data    host write byte
//   busy       transmitter busy
//   data_valid registered one-cycle launch pulse
//   p_data     FIFO head byte, stable while an entry is outstanding
//   full       count == DEPTH
//   empty      count == 0
//   count      occupancy 0..DEPTH
//   overflow   sticky: a write was dropped while full
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame outstanding; launch the head byte when possible
// LAUNCH    | data_valid pulsed; waiting for busy to rise (with timeout)
// WAIT_DONE | frame in progress; pop the head when busy falls
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  busy,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]    TMO_ONE  = TMO_W'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  dv_q, dv_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_acc;
    logic                  pop;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign data_valid = dv_q;
    assign p_data     = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        dv_d    = 1'b0;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !busy) begin
                    dv_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // transmitter never picked the byte up: relaunch it
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (!busy) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // full is sampled before any same-cycle pop, so a write while full
        // is dropped even if the head is leaving this cycle
        wr_acc   = wr_en && !full;
        wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (wr_acc && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_acc && pop) begin
            count_d = count_q - CNT_ONE;
        end
        ovf_d = ovf_q | (wr_en & full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dv_q     <= 1'b0;
            tmo_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dv_q     <= dv_d;
            tmo_q    <= tmo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // storage needs no reset; contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed testbench for uart_tx_feeder.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       data_valid;
    logic [7:0] p_data;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    uart_tx_feeder #(
        .DATA_WIDTH(8),
        .DEPTH(8),
        .ADDR_WIDTH(3),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .busy(busy),
        .data_valid(data_valid),
        .p_data(p_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // step until data_valid is seen (or budget runs out); n = edges taken
    task automatic wait_dv(input string tag, input int max_wait, output int n);
        n = 0;
        while (!data_valid && n < max_wait) begin
            step();
            n++;
        end
        check({tag, "_dv_seen"}, {31'd0, data_valid}, 32'd1);
    endtask

    // model one TX frame: data_valid is high now, busy rises in the same
    // cycle, stays high for len cycles, then falls and the pop edge follows
    task automatic frame(input string tag, input logic [7:0] exp, input int len);
        logic [7:0] held;
        logic       ok;
        check({tag, "_pdata"}, {24'd0, p_data}, {24'd0, exp});
        busy = 1'b1;
        held = p_data;
        ok   = 1'b1;
        repeat (len) begin
            step();
            if (data_valid !== 1'b0 || p_data !== held) ok = 1'b0;
        end
        check({tag, "_window_stable"}, {31'd0, ok}, 32'd1);
        busy = 1'b0;
        step();
        check({tag, "_no_dv_at_pop"}, {31'd0, data_valid}, 32'd0);
    endtask

    task automatic idle_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            step();
            if (data_valid !== 1'b0) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        busy    = 1'b1;
        #12;
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full}, 32'd0);
        check("rst_dv",    {31'd0, data_valid}, 32'd0);
        check("rst_ovf",   {31'd0, overflow}, 32'd0);

        // ---- 1: single byte, busy high at reset release ----
        @(negedge clk);
        reset = 1'b0;
        step();
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("t1_count1", {28'd0, count}, 32'd1);
        idle_quiet("t1_no_launch_while_busy", 3);
        busy = 1'b0;
        wait_dv("t1", 4, n);
        check("t1_latency", n, 32'd1);
        frame("t1", 8'hA5, 11);
        check("t1_count0", {28'd0, count}, 32'd0);
        check("t1_empty",  {31'd0, empty}, 32'd1);
        idle_quiet("t1_no_second_pulse", 10);

        // ---- 2: three back-to-back bytes ----
        wr_en = 1'b1; wr_data = 8'h11;
        step();
        check("t2_no_dv_write_edge", {31'd0, data_valid}, 32'd0);
        wr_data = 8'h22;
        step();
        check("t2_first_dv", {31'd0, data_valid}, 32'd1);
        check("t2_first_pdata", {24'd0, p_data}, 32'h11);
        // TX accepts in this cycle while the host writes the third byte
        busy = 1'b1; wr_data = 8'h33;
        step();
        wr_en = 1'b0;
        check("t2_count3", {28'd0, count}, 32'd3);
        frame("t2a", 8'h11, 8);
        wait_dv("t2b", 4, n);
        check("t2b_gap", n, 32'd1);
        frame("t2b", 8'h22, 9);
        wait_dv("t2c", 4, n);
        check("t2c_gap", n, 32'd1);
        frame("t2c", 8'h33, 9);
        check("t2_empty", {31'd0, empty}, 32'd1);

        // ---- 4: transmitter never responds -> timed relaunch ----
        wr_en = 1'b1; wr_data = 8'h5C;
        step();
        wr_en = 1'b0;
        check("t4_no_dv_write_edge", {31'd0, data_valid}, 32'd0);
        wait_dv("t4_first", 4, n);
        check("t4_latency", n, 32'd1);
        for (int k = 0; k < 2; k++) begin
            step();
            wait_dv("t4_retry", 10, n);
            check("t4_period", n + 1, 32'd5);
            check("t4_pdata", {24'd0, p_data}, 32'h5C);
            check("t4_count", {28'd0, count}, 32'd1);
        end
        frame("t4_final", 8'h5C, 3);
        check("t4_empty", {31'd0, empty}, 32'd1);

        // ---- 3: overflow with busy held, then drain (pointer wrap) ----
        busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("t3_count8", {28'd0, count}, 32'd8);
        check("t3_full",   {31'd0, full}, 32'd1);
        check("t3_ovf",    {31'd0, overflow}, 32'd1);
        check("t3_head",   {24'd0, p_data}, 32'h00);
        busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_dv("t3", 4, n);
            check("t3_gap", n, 32'd1);
            frame("t3", 8'(i), 3);
        end
        check("t3_empty", {31'd0, empty}, 32'd1);
        idle_quiet("t3_byte8_never_sent", 10);

        // ---- 6: reset during WAIT_DONE with count=3 ----
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        busy = 1'b0;
        wait_dv("t6", 4, n);
        busy = 1'b1;
        step();
        step();
        check("t6_count3", {28'd0, count}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_count", {28'd0, count}, 32'd0);
        check("t6_rst_empty", {31'd0, empty}, 32'd1);
        check("t6_rst_dv",    {31'd0, data_valid}, 32'd0);
        check("t6_rst_ovf",   {31'd0, overflow}, 32'd0);
        busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle_quiet("t6_no_pulse_after_release", 10);

        // ---- 5: write while full on the pop cycle ----
        busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("t5_full", {31'd0, full}, 32'd1);
        check("t5_ovf_clear", {31'd0, overflow}, 32'd0);
        busy = 1'b0;
        wait_dv("t5", 4, n);
        check("t5_pdata", {24'd0, p_data}, 32'h80);
        busy = 1'b1;
        repeat (4) step();
        busy = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        check("t5_count7", {28'd0, count}, 32'd7);
        check("t5_ovf_set", {31'd0, overflow}, 32'd1);
        check("t5_not_full", {31'd0, full}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            wait_dv("t5_drain", 4, n);
            check("t5_gap", n, 32'd1);
            frame("t5_drain", 8'h80 + 8'(i), 2);
        end
        check("t5_empty", {31'd0, empty}, 32'd1);
        idle_quiet("t5_dropped_never_sent", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
